multicycle_controller: RTL
==========================

# multicycle_controller

Multicycle control unit for the MIPS-subset processor: a Moore FSM that sequences each instruction over 3–5 states and drives every datapath strobe and mux select. It replaces the single-cycle decoder, which drives controls combinationally from the opcode. It adds a memory ready handshake, an optional `addi` path, illegal-opcode detection and a retired-instruction counter. It sits between the instruction register and the shared datapath and memory port.

## Interface
- `OP_W`, 6: opcode width.
- `EN_ADDI`, 1: 1 enables `addi` (opcode 001000); 0 treats it as illegal.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `op`  in  `OP_W`: opcode field from the instruction register; sampled only in DECODE.
- `mem_ready`  in  1: memory completes the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1: standard multicycle strobes and selects.
- `ALUSrcB`  out  2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- `ALUOp`  out  2: 00 = add, 01 = subtract, 10 = decode `funct`. Goes to the existing ALU controller as `{ALUOp1, ALUOp0}`.
- `PCSource`  out  2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state_o`  out  4: current state encoding, for debug.
- `illegal`  out  1: one-cycle pulse when DECODE sees an unsupported opcode.
- `instr_done`  out  1: one-cycle pulse in the final state of each completed instruction.
- `retired`  out  `CNT_W`: count of completed instructions.

## Operation
- **States (4-bit):** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 go to FETCH.
- **FETCH:** `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- **DECODE:** `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00. Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 with `EN_ADDI`=1 → ADDIEX
  - anything else → FETCH, with `illegal`=1 in the DECODE cycle
- **MEMADR:** `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next state is MEMRD for lw, MEMWR for sw. The opcode is held in a register captured in DECODE.
- **MEMRD:** `MemRead`=1, `IorD`=1. Wait for `mem_ready`, then go to MEMWB.
- **MEMWB:** `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Then FETCH.
- **MEMWR:** `MemWrite`=1, `IorD`=1. Wait for `mem_ready`, then go to FETCH.
- **EXEC:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Then RWB.
- **RWB:** `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Then FETCH.
- **BRANCH:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. Then FETCH.
- **JUMP:** `PCWrite`=1, `PCSource`=10. Then FETCH.
- **ADDIEX:** `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Then ADDIWB.
- **ADDIWB:** `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Then FETCH.
- **Unlisted outputs** are 0 in every state.
- **`instr_done`** is high in:
  - MEMWB, RWB, BRANCH, JUMP and ADDIWB, unconditionally;
  - MEMWR, only in the cycle where `mem_ready`=1.
- **Counter:** `retired` increments on each cycle with `instr_done`=1. It wraps modulo 2^`CNT_W` with no saturation.
- **Ignored handshake:** `mem_ready` has no effect outside FETCH, MEMRD and MEMWR.

## Timing
- **Reset:** state=FETCH, `retired`=0, captured opcode=0.
  - While `rst_n`=0, these outputs are forced to 0: `PCWrite`, `PCWriteCond`, `IRWrite`, `RegWrite`, `MemWrite`, `MemRead`, `illegal`, `instr_done`.
  - All other outputs hold their FETCH values.
- **Reset mid-instruction:** abandons the instruction with no partial write; it is not counted.
- **Cycle counts, no wait states:** lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
  - Each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- **Output style:** outputs are combinational from the registered state, plus the `mem_ready` terms listed above. There is no output register stage.
- **Opcode sampling:** `op` changing outside DECODE has no effect.

## Structure
- Package `ctrl_pkg` holds:
  - state enum;
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`);
  - `ALUOp`, `ALUSrcB` and `PCSource` encodings.
- One sub-module, `mc_out_decode`: a purely combinational map from state and `mem_ready` to the strobe bundle.
- The top level holds the state register, the captured opcode and the counter.

## Test plan
- Reset asserted with `mem_ready`=1 → `state_o`=0, all write strobes 0, `retired`=0. Release reset → `IRWrite`=`PCWrite`=1 in the first FETCH cycle.
- lw (100011) with `mem_ready` held 1 → states 0,1,2,3,4; `RegWrite`=`MemtoReg`=1 in cycle 5; `retired` +1.
- sw with `mem_ready` low for 2 cycles in MEMWR → 6 total cycles; `MemWrite` high for 3 cycles; `instr_done` only in the last.
- beq, then j, then R-type, back-to-back → 3+3+4=10 cycles; `PCWriteCond` only in state 8; `PCSource`=10 in state 9; `ALUOp`=10 in state 6.
- Opcode 111111, then 001000 built with `EN_ADDI`=0 → `illegal` pulses twice; `retired` unchanged. With `EN_ADDI`=1, 001000 → states 10,11, `RegWrite`=1, `RegDst`=0.
- `CNT_W`=3, run 9 j instructions → `retired` reads 1; `rst_n` dropped in MEMRD → immediate FETCH, no `RegWrite`.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control unit.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    // DECODE successor; S_FETCH doubles as the "unsupported opcode" answer.
    function automatic state_e decode_next(input logic [5:0] opcode, input logic en_addi);
        state_e nxt;
        nxt = S_FETCH;
        case (opcode)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
            OP_ADDI:      nxt = en_addi ? S_ADDIEX : S_FETCH;
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore output map: state (plus the memory handshake) to the datapath strobe bundle.
module mc_out_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            // A store retires only in the cycle memory accepts it.
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.ior_d      = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: state register, captured opcode, retired counter and reset gating.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter bit EN_ADDI = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state_o,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    logic [3:0]       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [5:0]       op_cur, op_held;
    logic             illegal_raw;
    ctrl_t            ctrl;

    assign op_cur  = 6'(op);
    assign op_held = 6'(op_q);

    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d = decode_next(op_cur, EN_ADDI);
                op_d    = op;
            end
            S_MEMADR: state_d = (op_held == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        illegal_raw = (state_q == S_DECODE) && (decode_next(op_cur, EN_ADDI) == S_FETCH);
        retired_d   = retired_q + CNT_W'(ctrl.instr_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Side-effecting strobes are masked by reset so an aborted instruction writes nothing.
    assign PCWrite     = ctrl.pc_write      & rst_n;
    assign PCWriteCond = ctrl.pc_write_cond & rst_n;
    assign IRWrite     = ctrl.ir_write      & rst_n;
    assign RegWrite    = ctrl.reg_write     & rst_n;
    assign MemWrite    = ctrl.mem_write     & rst_n;
    assign MemRead     = ctrl.mem_read      & rst_n;
    assign illegal     = illegal_raw        & rst_n;
    assign instr_done  = ctrl.instr_done    & rst_n;
    assign IorD        = ctrl.ior_d;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign state_o     = state_q;
    assign retired     = retired_q;

endmodule
